// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared widths, feeder state enum and count helper
package stream_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int COUNT_WIDTH    = 16;

  typedef enum logic [1:0] {
    ST_FEED,
    ST_FLUSH,
    ST_DRAIN,
    ST_CLEAR
  } feed_state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  // Saturating increment so a very long frame reports 65535 instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_ONE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, power-of-two depth, sync active-low reset
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/stream_feeder.sv
// rtl/stream_feeder.sv - frames a sample stream into a second-largest tracker and collects per-frame results
module stream_feeder
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_last,
  output logic [DATA_WIDTH-1:0]  feed_data,
  output logic                   feed_clr_n,
  input  logic [DATA_WIDTH-1:0]  trk_dout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_WIDTH-1:0]  res_data,
  output logic [COUNT_WIDTH-1:0] res_count
);

  feed_state_t            state_q;
  feed_state_t            state_d;
  logic                   pop;
  logic                   capture;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_WIDTH:0]    fifo_rdata;
  logic [COUNT_WIDTH-1:0] frame_cnt;

  assign s_ready = !fifo_full;

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (s_valid),
    .push_data ({s_data, s_last}),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_FEED, ST_CLEAR: begin
        // CLEAR may already pop the next frame's first sample; it lands after the clear.
        pop = !fifo_empty;
        if (pop && fifo_rdata[0]) state_d = ST_FLUSH;
        else                      state_d = ST_FEED;
      end
      ST_FLUSH: state_d = ST_DRAIN;
      ST_DRAIN: begin
        capture = !res_valid || res_ready;
        if (capture) state_d = ST_CLEAR;
      end
      default: state_d = ST_FEED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_FEED;
      feed_data  <= '0;
      feed_clr_n <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_count  <= '0;
      frame_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      feed_data  <= pop ? fifo_rdata[DATA_WIDTH:1] : '0;
      feed_clr_n <= (state_d != ST_CLEAR);

      if (capture)  frame_cnt <= '0;
      else if (pop) frame_cnt <= sat_inc(frame_cnt);

      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= trk_dout;
        res_count <= frame_cnt;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_feeder.sv
// tb/tb_stream_feeder.sv - directed bench with attached tracker and result scoreboard
module tb_stream_feeder;
  import stream_pkg::*;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [15:0]   count;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic [DW-1:0] feed_data;
  logic          feed_clr_n;
  logic [DW-1:0] trk_dout;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic [15:0]   res_count;

  logic [DW-1:0] t_max;
  logic [DW-1:0] t_sec;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [DW-1:0] fd_log[$];
  logic          cl_log[$];

  stream_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .feed_data(feed_data), .feed_clr_n(feed_clr_n), .trk_dout(trk_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_count(res_count)
  );

  always #5 clk = ~clk;

  // Downstream second-largest tracker, cleared synchronously by feed_clr_n.
  always @(posedge clk) begin
    if (!feed_clr_n) begin
      t_max <= '0;
      t_sec <= '0;
    end else if (feed_data > t_max) begin
      t_sec <= t_max;
      t_max <= feed_data;
    end else if (feed_data > t_sec) begin
      t_sec <= feed_data;
    end
  end
  assign trk_dout = t_sec;

  always @(negedge clk) begin
    fd_log.push_back(feed_data);
    cl_log.push_back(feed_clr_n);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout/missing expected event", tag);
  endtask

  function automatic exp_t model(input logic [DW-1:0] v[$]);
    exp_t e;
    int mi = 0;
    logic [DW-1:0] sec = '0;
    for (int i = 1; i < v.size(); i++) if (v[i] > v[mi]) mi = i;
    for (int i = 0; i < v.size(); i++) if (i != mi && v[i] > sec) sec = v[i];
    e.data = sec;
    e.count = 16'(v.size());
    return e;
  endfunction

  task automatic push(input logic [DW-1:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) fail_now("push_timeout");
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] v[$]);
    sb.push_back(model(v));
    for (int i = 0; i < v.size(); i++) push(v[i], i == v.size() - 1);
  endtask

  task automatic get_result(input string tag);
    exp_t e;
    int n = 0;
    @(negedge clk);
    res_ready = 1'b1;
    while (!res_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) fail_now({tag, "_timeout"});
    else if (sb.size() == 0) fail_now({tag, "_unexpected"});
    else begin
      e = sb.pop_front();
      check({tag, "_data"}, res_data, e.data);
      check({tag, "_count"}, res_count, e.count);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] v[$];
    logic [DW-1:0] fed[$];
    int idx;

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_feed_data", feed_data, 0);
    check("rst_clr_n", feed_clr_n, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_count", res_count, 0);
    check("rst_s_ready", s_ready, 1);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_clr_n", feed_clr_n, 1);

    // Basic frame with timing of feed and clear.
    fd_log.delete();
    cl_log.delete();
    res_ready = 1'b1;
    v = '{5, 9, 3, 7};
    send_frame(v);
    get_result("f5937");
    repeat (4) @(negedge clk);
    idx = -1;
    for (int i = 0; i < fd_log.size(); i++) if (idx < 0 && fd_log[i] == 5) idx = i;
    if (idx < 0 || idx + 6 >= fd_log.size()) fail_now("f5937_feed_seq");
    else begin
      for (int k = 0; k < 4; k++) check("f5937_feed", fd_log[idx + k], v[k]);
      check("f5937_clr_drain", cl_log[idx + 4], 1);
      check("f5937_clr_clear", cl_log[idx + 5], 0);
      check("f5937_clr_after", cl_log[idx + 6], 1);
      check("f5937_feed_zero", fd_log[idx + 4], 0);
    end

    v = '{42};
    send_frame(v);
    get_result("single");

    v = '{0, 0, 0};
    send_frame(v);
    get_result("zeros");

    // Back-pressured results: first held in res regs, second parked in DRAIN.
    res_ready = 1'b0;
    v = '{1, 2};
    send_frame(v);
    v = '{8, 8, 4};
    send_frame(v);
    repeat (12) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, sb[0].data);
      check("hold_count", res_count, sb[0].count);
      check("hold_no_clear", feed_clr_n, 1);
      @(negedge clk);
    end

    // Fill the FIFO while stalled in DRAIN.
    fd_log.delete();
    v = '{30, 10, 50, 20, 40, 5};
    sb.push_back(model(v));
    for (int i = 0; i < DEPTH; i++) push(v[i], 1'b0);
    @(negedge clk);
    check("full_s_ready", s_ready, 0);
    repeat (3) @(negedge clk);
    check("full_s_ready_hold", s_ready, 0);
    get_result("bp_first");
    @(negedge clk);
    check("no_bubble_valid", res_valid, 1);
    get_result("bp_second");
    push(v[4], 1'b0);
    push(v[5], 1'b1);
    get_result("bp_third");
    repeat (3) @(negedge clk);
    fed.delete();
    foreach (fd_log[i]) if (fd_log[i] != 0) fed.push_back(fd_log[i]);
    check("order_len", fed.size(), v.size());
    if (fed.size() == v.size())
      for (int k = 0; k < v.size(); k++) check("order_val", fed[k], v[k]);

    // Mid-frame reset discards the partial frame.
    push(6, 1'b0);
    push(11, 1'b0);
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_clr_n", feed_clr_n, 0);
    check("mid_rst_feed", feed_data, 0);
    check("mid_rst_s_ready", s_ready, 1);
    resetn = 1'b1;
    @(negedge clk);
    check("mid_rst_release_clr_n", feed_clr_n, 1);
    v = '{2, 1};
    send_frame(v);
    get_result("post_reset");
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
